// File: rtl/sram_like_arbiter.sv
// Merges NUM_CH sram-like request channels onto one variable-latency memory port,
// routing each in-order response back to its issuing channel via a tracking FIFO.
module sram_like_arbiter #(
    parameter int unsigned NUM_CH    = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_OUTST = 4,
    parameter int unsigned RR_MODE   = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_CH-1:0]                    ch_req,
    input  logic [NUM_CH-1:0]                    ch_wr,
    input  logic [NUM_CH*DATA_W/8-1:0]           ch_wstrb,
    input  logic [NUM_CH*ADDR_W-1:0]             ch_addr,
    input  logic [NUM_CH*DATA_W-1:0]             ch_wdata,
    output logic [NUM_CH-1:0]                    ch_addr_ok,
    output logic [NUM_CH-1:0]                    ch_data_ok,
    output logic [DATA_W-1:0]                    ch_rdata,
    output logic                                 mem_req,
    output logic                                 mem_wr,
    output logic [DATA_W/8-1:0]                  mem_wstrb,
    output logic [ADDR_W-1:0]                    mem_addr,
    output logic [DATA_W-1:0]                    mem_wdata,
    input  logic                                 mem_addr_ok,
    input  logic                                 mem_data_ok,
    input  logic [DATA_W-1:0]                    mem_rdata,
    output logic [$clog2(MAX_OUTST+1)-1:0]       outst_cnt,
    output logic                                 err_spurious
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CH_W   = $clog2(NUM_CH);
    localparam int unsigned PTR_W  = $clog2(MAX_OUTST);
    localparam int unsigned CNT_W  = $clog2(MAX_OUTST + 1);

    typedef enum logic {
        LK_OPEN,
        LK_HELD
    } lock_state_t;

    lock_state_t       lock_state;
    lock_state_t       lock_state_nxt;
    logic [CH_W-1:0]   lock_ch;
    logic [CH_W-1:0]   lock_ch_nxt;

    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   rr_next;
    logic [CH_W-1:0]   grant;
    logic              grant_found;
    int unsigned       rr_idx;

    logic [CH_W-1:0]   fifo_mem [MAX_OUTST];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic              accept;
    logic              pop;
    logic [CH_W-1:0]   head_ch;

    assign fifo_full  = (cnt_q == CNT_W'(MAX_OUTST));
    assign fifo_empty = (cnt_q == '0);
    assign head_ch    = fifo_mem[rd_ptr];

    // Grant select: a held lock overrides any fresh arbitration result.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        rr_idx      = 0;
        if (lock_state == LK_HELD) begin
            grant       = lock_ch;
            grant_found = 1'b1;
        end else if (RR_MODE != 0) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                rr_idx = int'(rr_ptr) + k;
                if (rr_idx >= NUM_CH) begin
                    rr_idx = rr_idx - NUM_CH;
                end
                if (!grant_found && ch_req[CH_W'(rr_idx)]) begin
                    grant       = CH_W'(rr_idx);
                    grant_found = 1'b1;
                end
            end
        end else begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (!grant_found && ch_req[CH_W'(k)]) begin
                    grant       = CH_W'(k);
                    grant_found = 1'b1;
                end
            end
        end
    end

    // Nothing is offered to memory while in reset or while every tracking slot is in use.
    assign mem_req   = !reset && grant_found && !fifo_full;
    assign accept    = mem_req && mem_addr_ok;
    assign pop       = mem_data_ok && !fifo_empty;

    assign mem_wr    = ch_wr[grant];
    assign mem_wstrb = ch_wstrb[int'(grant)*STRB_W +: STRB_W];
    assign mem_addr  = ch_addr[int'(grant)*ADDR_W +: ADDR_W];
    assign mem_wdata = ch_wdata[int'(grant)*DATA_W +: DATA_W];

    assign ch_rdata     = mem_rdata;
    assign outst_cnt    = cnt_q;
    assign err_spurious = err_q;

    assign rr_next = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);

    // One-hot handshake returns toward the channels.
    always_comb begin
        ch_addr_ok = '0;
        ch_data_ok = '0;
        if (accept) begin
            ch_addr_ok[grant] = 1'b1;
        end
        if (pop) begin
            ch_data_ok[head_ch] = 1'b1;
        end
    end

    // Lock state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_state <= LK_OPEN;
            lock_ch    <= '0;
        end else begin
            lock_state <= lock_state_nxt;
            lock_ch    <= lock_ch_nxt;
        end
    end

    // Lock next state: pin the offered channel until memory takes it.
    always_comb begin
        lock_state_nxt = lock_state;
        lock_ch_nxt    = lock_ch;
        if (accept) begin
            lock_state_nxt = LK_OPEN;
        end else if (mem_req) begin
            lock_state_nxt = LK_HELD;
            lock_ch_nxt    = grant;
        end
    end

    // Tracking FIFO pointers, occupancy, rr pointer and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (RR_MODE != 0) begin
                    rr_ptr <= rr_next;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(accept) - CNT_W'(pop);
            if (mem_data_ok && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

    // FIFO storage holds only the issuing channel index; no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_mem[wr_ptr] <= grant;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: a fixed-priority 2-channel and a round-robin 3-channel
// instance, checked each cycle against a queue-based reference model.
module tb_sram_like_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;
    localparam int MO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Generic per-instance stimulus (index 0 = fixed priority, 1 = round robin)
    logic [7:0]  req [2];
    logic [7:0]  wr  [2];
    logic [3:0]  wstrb [2][8];
    logic [31:0] addr  [2][8];
    logic [31:0] wdata [2][8];
    logic        aok [2];
    logic        dok [2];
    logic [31:0] rdata_in [2];

    logic [1:0]   fp_req, fp_wr, fp_addr_ok, fp_data_ok;
    logic [7:0]   fp_wstrb;
    logic [63:0]  fp_addr, fp_wdata;
    logic [31:0]  fp_rdata, fp_mem_addr, fp_mem_wdata;
    logic         fp_mem_req, fp_mem_wr, fp_err;
    logic [3:0]   fp_mem_wstrb;
    logic [2:0]   fp_outst;

    logic [2:0]   rr_req, rr_wr, rr_addr_ok, rr_data_ok;
    logic [11:0]  rr_wstrb;
    logic [95:0]  rr_addr, rr_wdata;
    logic [31:0]  rr_rdata, rr_mem_addr, rr_mem_wdata;
    logic         rr_mem_req, rr_mem_wr, rr_err;
    logic [3:0]   rr_mem_wstrb;
    logic [2:0]   rr_outst;

    logic [7:0]  got_aok [2];
    logic [7:0]  got_dok [2];
    logic        got_mreq [2];
    logic        got_mwr [2];
    logic        got_err [2];
    logic [3:0]  got_mstrb [2];
    logic [31:0] got_maddr [2];
    logic [31:0] got_mwdata [2];
    logic [31:0] got_rdata [2];
    logic [2:0]  got_outst [2];

    always_comb begin
        fp_req = req[0][1:0];
        fp_wr  = wr[0][1:0];
        rr_req = req[1][2:0];
        rr_wr  = wr[1][2:0];
        for (int i = 0; i < 2; i++) begin
            fp_addr[i*32 +: 32]  = addr[0][i];
            fp_wdata[i*32 +: 32] = wdata[0][i];
            fp_wstrb[i*4 +: 4]   = wstrb[0][i];
        end
        for (int i = 0; i < 3; i++) begin
            rr_addr[i*32 +: 32]  = addr[1][i];
            rr_wdata[i*32 +: 32] = wdata[1][i];
            rr_wstrb[i*4 +: 4]   = wstrb[1][i];
        end
    end

    always_comb begin
        got_aok[0] = 8'(fp_addr_ok);   got_aok[1] = 8'(rr_addr_ok);
        got_dok[0] = 8'(fp_data_ok);   got_dok[1] = 8'(rr_data_ok);
        got_mreq[0] = fp_mem_req;      got_mreq[1] = rr_mem_req;
        got_mwr[0] = fp_mem_wr;        got_mwr[1] = rr_mem_wr;
        got_err[0] = fp_err;           got_err[1] = rr_err;
        got_mstrb[0] = fp_mem_wstrb;   got_mstrb[1] = rr_mem_wstrb;
        got_maddr[0] = fp_mem_addr;    got_maddr[1] = rr_mem_addr;
        got_mwdata[0] = fp_mem_wdata;  got_mwdata[1] = rr_mem_wdata;
        got_rdata[0] = fp_rdata;       got_rdata[1] = rr_rdata;
        got_outst[0] = fp_outst;       got_outst[1] = rr_outst;
    end

    sram_like_arbiter #(.NUM_CH(2), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO), .RR_MODE(0)) dut_fp (
        .clk(clk), .reset(reset),
        .ch_req(fp_req), .ch_wr(fp_wr), .ch_wstrb(fp_wstrb), .ch_addr(fp_addr), .ch_wdata(fp_wdata),
        .ch_addr_ok(fp_addr_ok), .ch_data_ok(fp_data_ok), .ch_rdata(fp_rdata),
        .mem_req(fp_mem_req), .mem_wr(fp_mem_wr), .mem_wstrb(fp_mem_wstrb), .mem_addr(fp_mem_addr),
        .mem_wdata(fp_mem_wdata), .mem_addr_ok(aok[0]), .mem_data_ok(dok[0]), .mem_rdata(rdata_in[0]),
        .outst_cnt(fp_outst), .err_spurious(fp_err)
    );

    sram_like_arbiter #(.NUM_CH(3), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO), .RR_MODE(1)) dut_rr (
        .clk(clk), .reset(reset),
        .ch_req(rr_req), .ch_wr(rr_wr), .ch_wstrb(rr_wstrb), .ch_addr(rr_addr), .ch_wdata(rr_wdata),
        .ch_addr_ok(rr_addr_ok), .ch_data_ok(rr_data_ok), .ch_rdata(rr_rdata),
        .mem_req(rr_mem_req), .mem_wr(rr_mem_wr), .mem_wstrb(rr_mem_wstrb), .mem_addr(rr_mem_addr),
        .mem_wdata(rr_mem_wdata), .mem_addr_ok(aok[1]), .mem_data_ok(dok[1]), .mem_rdata(rdata_in[1]),
        .outst_cnt(rr_outst), .err_spurious(rr_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: queue of issuing channels in acceptance order
    int q_fp[$];
    int q_rr[$];
    int nch [2] = '{2, 3};
    bit rrm [2] = '{1'b0, 1'b1};
    int lock_m [2];
    int rr_m [2];
    bit err_m [2];
    int acc_ch [2];

    function automatic int qsize(input int d);
        return (d == 0) ? q_fp.size() : q_rr.size();
    endfunction

    function automatic int qfront(input int d);
        return (d == 0) ? q_fp[0] : q_rr[0];
    endfunction

    task automatic model_reset();
        q_fp.delete();
        q_rr.delete();
        for (int d = 0; d < 2; d++) begin
            lock_m[d] = -1; rr_m[d] = 0; err_m[d] = 1'b0; acc_ch[d] = -1;
        end
    endtask

    task automatic model_check(input int d);
        int    cnt, g, c;
        bit    mreq, acc, pop;
        string p;
        p   = $sformatf("d%0d", d);
        cnt = qsize(d);
        g   = -1;
        if (lock_m[d] >= 0) g = lock_m[d];
        else begin
            for (int k = 0; k < nch[d]; k++) begin
                c = rrm[d] ? (rr_m[d] + k) % nch[d] : k;
                if (g < 0 && req[d][c]) g = c;
            end
        end
        mreq = (g >= 0) && (cnt < MO);
        acc  = mreq && aok[d];
        pop  = dok[d] && (cnt > 0);
        chk({p, "_mem_req"}, 64'(got_mreq[d]), 64'(mreq));
        chk({p, "_addr_ok"}, 64'(got_aok[d]), acc ? (64'd1 << g) : 64'd0);
        chk({p, "_data_ok"}, 64'(got_dok[d]), pop ? (64'd1 << qfront(d)) : 64'd0);
        chk({p, "_rdata"}, 64'(got_rdata[d]), 64'(rdata_in[d]));
        chk({p, "_outst"}, 64'(got_outst[d]), 64'(cnt));
        chk({p, "_err"}, 64'(got_err[d]), 64'(err_m[d]));
        if (mreq) begin
            chk({p, "_mem_addr"}, 64'(got_maddr[d]), 64'(addr[d][g]));
            chk({p, "_mem_wr"}, 64'(got_mwr[d]), 64'(wr[d][g]));
            chk({p, "_mem_wstrb"}, 64'(got_mstrb[d]), 64'(wstrb[d][g]));
            chk({p, "_mem_wdata"}, 64'(got_mwdata[d]), 64'(wdata[d][g]));
        end
        if (pop) begin
            if (d == 0) void'(q_fp.pop_front()); else void'(q_rr.pop_front());
        end
        if (acc) begin
            if (d == 0) q_fp.push_back(g); else q_rr.push_back(g);
        end
        if (dok[d] && cnt == 0) err_m[d] = 1'b1;
        if (acc) lock_m[d] = -1;
        else if (mreq) lock_m[d] = g;
        if (acc && rrm[d]) rr_m[d] = (g + 1) % nch[d];
        acc_ch[d] = acc ? g : -1;
    endtask

    task automatic settle();
        @(negedge clk);
        model_check(0);
        model_check(1);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int d, input logic [7:0] r, input bit a, input bit k, input logic [31:0] rd);
        req[d] = r; aok[d] = a; dok[d] = k; rdata_in[d] = rd;
    endtask

    task automatic zero_inputs();
        for (int d = 0; d < 2; d++) begin
            req[d] = '0; wr[d] = '0; aok[d] = 1'b0; dok[d] = 1'b0; rdata_in[d] = '0;
            for (int c = 0; c < 8; c++) begin
                addr[d][c]  = 32'h1000 * (c + 1) + 32'(d);
                wdata[d][c] = 32'hD000_0000 + 32'(c);
                wstrb[d][c] = 4'hF;
            end
        end
    endtask

    task automatic drive_random(input int d);
        if (acc_ch[d] >= 0) req[d][acc_ch[d]] = 1'b0;
        for (int c = 0; c < nch[d]; c++) begin
            if (!req[d][c] && $urandom_range(0, 2) == 0) begin
                req[d][c]   = 1'b1;
                addr[d][c]  = $urandom;
                wr[d][c]    = 1'($urandom_range(0, 1));
                wdata[d][c] = $urandom;
                wstrb[d][c] = 4'($urandom);
            end
        end
        aok[d]      = ($urandom_range(0, 9) < 6);
        dok[d]      = ($urandom_range(0, 9) < 4);
        rdata_in[d] = $urandom;
    endtask

    int          order [4]  = '{0, 1, 1, 0};
    logic [31:0] vals  [5]  = '{32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003, 32'hD0D0_0004, 32'hE0E0_0005};
    int          dseq  [5]  = '{1, 2, 2, 1, 1};
    int          aseq  [5]  = '{0, 1, 0, 0, 0};

    initial begin
        reset = 1'b1;
        zero_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        settle();
        for (int d = 0; d < 2; d++) begin
            chk("rst_mem_req", 64'(got_mreq[d]), 0);
            chk("rst_outst", 64'(got_outst[d]), 0);
            chk("rst_err", 64'(got_err[d]), 0);
        end
        adv();

        // Fixed priority: ch0 always wins while it requests
        for (int i = 0; i < 3; i++) begin
            drv(0, 8'b11, 1, 0, 0); settle(); chk("prio_aok", 64'(got_aok[0]), 1); adv();
        end
        drv(0, 8'b10, 1, 0, 0); settle(); chk("prio_ch1", 64'(got_aok[0]), 2); adv();
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 0, 1, vals[i]); settle(); chk("prio_dok", 64'(got_dok[0]), (i < 3) ? 1 : 2); adv();
        end
        drv(0, 0, 0, 0, 0); settle(); chk("prio_outst0", 64'(got_outst[0]), 0); adv();

        // Lock: ch1 stays offered while memory stalls, ch0 waits
        addr[0][1] = 32'h100; addr[0][0] = 32'h200;
        for (int i = 0; i < 3; i++) begin
            drv(0, (i == 0) ? 8'b10 : 8'b11, 0, 0, 0); settle();
            chk("lock_addr", 64'(got_maddr[0]), 64'h100);
            chk("lock_aok", 64'(got_aok[0]), 0);
            adv();
        end
        drv(0, 8'b11, 1, 0, 0); settle(); chk("lock_acc1", 64'(got_aok[0]), 2); adv();
        drv(0, 8'b01, 1, 0, 0); settle();
        chk("lock_acc0", 64'(got_aok[0]), 1);
        chk("lock_addr0", 64'(got_maddr[0]), 64'h200);
        adv();
        drv(0, 0, 0, 1, 1); settle(); chk("lock_dok1", 64'(got_dok[0]), 2); adv();
        drv(0, 0, 0, 1, 2); settle(); chk("lock_dok0", 64'(got_dok[0]), 1); adv();

        // Full and in-order return
        for (int i = 0; i < 4; i++) begin
            drv(0, 8'(1 << order[i]), 1, 0, 0); settle();
            chk("full_fill_aok", 64'(got_aok[0]), 64'(1 << order[i])); adv();
        end
        drv(0, 8'b01, 1, 0, 0); settle();
        chk("full_outst", 64'(got_outst[0]), 4);
        chk("full_mreq", 64'(got_mreq[0]), 0);
        adv();
        for (int i = 0; i < 5; i++) begin
            drv(0, (i < 2) ? 8'b01 : 8'b00, 1, 1, vals[i]); settle();
            chk("order_dok", 64'(got_dok[0]), 64'(dseq[i]));
            chk("order_rdata", 64'(got_rdata[0]), 64'(vals[i]));
            chk("order_aok", 64'(got_aok[0]), 64'(aseq[i]));
            adv();
        end
        drv(0, 0, 0, 0, 0); settle(); chk("order_outst0", 64'(got_outst[0]), 0); adv();

        // Simultaneous push and pop
        drv(0, 8'b01, 1, 0, 0); settle(); adv();
        drv(0, 8'b01, 1, 0, 0); settle(); adv();
        drv(0, 8'b10, 1, 1, 32'h5A5A); settle();
        chk("sim_aok", 64'(got_aok[0]), 2);
        chk("sim_dok", 64'(got_dok[0]), 1);
        adv();
        drv(0, 0, 0, 0, 0); settle(); chk("sim_outst", 64'(got_outst[0]), 2); adv();
        drv(0, 0, 0, 1, 0); settle(); chk("sim_drain0", 64'(got_dok[0]), 1); adv();
        drv(0, 0, 0, 1, 0); settle(); chk("sim_drain1", 64'(got_dok[0]), 2); adv();

        // Spurious response with empty FIFO
        drv(0, 0, 0, 1, 0); settle(); chk("spur_dok", 64'(got_dok[0]), 0); adv();
        drv(0, 0, 0, 0, 0); settle(); chk("spur_err", 64'(got_err[0]), 1); adv();
        repeat (3) begin settle(); adv(); end
        settle(); chk("spur_err_sticky", 64'(got_err[0]), 1); adv();

        // Round robin over three channels
        for (int k = 0; k < 6; k++) begin
            drv(1, 8'b111, 1, (k > 0), 32'(k)); settle();
            chk("rr_grant", 64'(got_aok[1]), 64'(1 << (k % 3))); adv();
        end
        drv(1, 0, 0, 1, 0); settle(); chk("rr_drain", 64'(got_dok[1]), 4); adv();
        drv(1, 0, 0, 0, 0);

        // Asynchronous reset mid-cycle with work outstanding
        for (int i = 0; i < 3; i++) begin
            drv(0, 8'b01, 1, 0, 0); settle(); adv();
        end
        drv(0, 8'b01, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("arst_outst", 64'(got_outst[0]), 0);
        chk("arst_err", 64'(got_err[0]), 0);
        chk("arst_mreq", 64'(got_mreq[0]), 0);
        chk("arst_aok", 64'(got_aok[0]), 0);
        chk("arst_dok", 64'(got_dok[0]), 0);
        zero_inputs();
        model_reset();
        adv();
        reset = 1'b0;
        settle(); chk("arst_after_outst", 64'(got_outst[0]), 0); adv();

        // Randomized traffic on both instances
        for (int n = 0; n < 1500; n++) begin
            drive_random(0);
            drive_random(1);
            settle();
            adv();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
